uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200); legal range 4..65535.
REQ-002 clock  input  1  single clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 rx  input  1  asynchronous serial line; idles high.
REQ-005 uart_rx_data  output  9  last correctly received frame payload, bit 0 first on the wire.
REQ-006 uart_rx_valid  output  1  one-cycle pulse; uart_rx_data is new and valid in that cycle.
REQ-007 framing_error  output  1  one-cycle pulse; stop bit sampled low.
REQ-008 parity_error  output  1  one-cycle pulse; parity mismatch (REQ-026).
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer reset to 1; all sampling uses the synchronized value.
REQ-011 State machine: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
REQ-012 IDLE: synchronized rx = 0 -> START, bit counter cleared.
REQ-013 START: at cycle CLKS_PER_BIT/2 (integer division) sample rx; 1 -> IDLE, no output (glitch reject); 0 -> DATA, bit counter restarts.
REQ-014 DATA: sample every CLKS_PER_BIT cycles, mid-bit; shift in LSB first; bit index 4 bits, 0..8; after 9th bit -> PARITY or STOP.
REQ-015 STOP: sample CLKS_PER_BIT cycles after last data/parity sample; 1 and no parity error -> IDLE, uart_rx_valid pulse.
REQ-016 STOP sampled 0 -> framing_error pulse, no uart_rx_valid, uart_rx_data unchanged, -> WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until synchronized rx = 1, then -> IDLE; a held-low line (break) produces exactly one framing_error.
REQ-018 uart_rx_data SHALL update only in the uart_rx_valid cycle and hold until the next one.
REQ-019 uart_rx_valid SHALL assert the cycle after the stop-bit sample; no backpressure, no internal buffering, consumer must accept every pulse.
REQ-020 uart_rx_valid, framing_error, parity_error SHALL never assert in the same cycle.
REQ-021 Bit counter width $clog2(CLKS_PER_BIT)+1; counter SHALL never wrap mid-bit.
REQ-022 Back-to-back frames: a start bit immediately after the stop bit SHALL be accepted with no gap frames lost.

Reset
REQ-023 reset_n low: state IDLE, counters 0, shift register 0, uart_rx_data 9'h000, uart_rx_valid/framing_error/parity_error 0, busy 0, synchronizer 1.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame with no pulse; after release, reception restarts only on a new falling edge.

Configuration
REQ-025 Macro UART_RX_PARITY_EN selects a parity bit between data and stop.
REQ-026 Defined: PARITY state samples one bit; even parity over 9 data bits plus parity bit; mismatch -> parity_error pulse at stop sample time in place of uart_rx_valid, -> IDLE (or WAIT_HIGH if stop also low, framing_error takes priority).
REQ-027 Undefined: no PARITY state, frame is 11 bits, parity_error tied 0.

Verification (bench CLKS_PER_BIT = 16, macro undefined unless stated)
REQ-028 Frame 9'h1A5, stop high -> single uart_rx_valid, data 9'h1A5, 168..172 cycles after falling edge; busy low afterwards.
REQ-029 rx low pulse of 5 cycles, then high -> returns to IDLE, no pulse of any output.
REQ-030 Frame 9'h0FF with stop bit low, line then held low 500 cycles -> one framing_error, no valid, uart_rx_data keeps prior value, busy high until rx returns high.
REQ-031 Frames 9'h001 then 9'h100 back-to-back, zero idle -> two valid pulses, data 9'h001 then 9'h100.
REQ-032 reset_n pulsed low during data bit 4 of 9'h155 -> no pulse, outputs at reset values; following frame 9'h0AA received correctly.
REQ-033 UART_RX_PARITY_EN defined: 9'h003 with parity 0 -> valid, data 9'h003; 9'h003 with parity 1 -> parity_error only.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 9-bit serial receiver with mid-bit sampling and framing/parity error pulses.
// Ports: clock, reset_n (async active-low), rx (async serial in, idles high);
//        uart_rx_data/uart_rx_valid (payload + one-cycle strobe), framing_error and
//        parity_error (one-cycle pulses), busy (high outside IDLE).
// Optional feature: define UART_RX_PARITY_EN for an even parity bit between data and stop.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [8:0] uart_rx_data,
  output logic       uart_rx_valid,
  output logic       framing_error,
  output logic       parity_error,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;
  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    shift_q, shift_d, data_q, data_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;
  logic          rx_s;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d, perr_q, perr_d;
`endif
  assign rx_s          = sync_q[1];
  assign uart_rx_data  = data_q;
  assign uart_rx_valid = valid_q;
  assign framing_error = ferr_q;
  assign busy          = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
  assign parity_error  = perr_q;
`else
  assign parity_error  = 1'b0;
`endif
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end
  // The bit counter is cleared at every sample point, so it never wraps mid-bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d = '0;
        bit_d = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        shift_d = {rx_s, shift_q[8:1]};
        bit_d = bit_q + 4'd1;
`ifdef UART_RX_PARITY_EN
        if (bit_q == 4'd8) state_d = PARITY;
`else
        if (bit_q == 4'd8) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt_q == FULL) begin
        cnt_d = '0;
        par_d = rx_s;
        state_d = STOP;
      end
`endif
      STOP: if (cnt_q == FULL) begin
        cnt_d = '0;
        if (!rx_s) begin
          ferr_d = 1'b1;
          state_d = WAIT_HIGH;
        end
`ifdef UART_RX_PARITY_EN
        else if (^{shift_q, par_q}) begin
          perr_d = 1'b1;
          state_d = IDLE;
        end
`endif
        else begin
          valid_d = 1'b1;
          data_d = shift_q;
          state_d = IDLE;
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        state_d = rx_s ? IDLE : WAIT_HIGH;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
